// File: rtl/xc_malu_pkg.sv
// Shared definitions for the MALU sequencer and its packed adder.
//   - malu_state_e  : sequencer states (IDLE=0, RUN=1, DONE=2)
//   - CNT_W_DEFAULT : default iteration counter width
//   - LANE_BASE_*   : bit positions where a packed lane begins, per lane width
//   - lane_base()   : lane-base mask selected by the one-hot pw_* controls
package xc_malu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } malu_state_e;

  localparam int unsigned CNT_W_DEFAULT = 6;

  localparam logic [31:0] LANE_BASE_32 = 32'h0000_0001;
  localparam logic [31:0] LANE_BASE_16 = 32'h0001_0001;
  localparam logic [31:0] LANE_BASE_8  = 32'h0101_0101;
  localparam logic [31:0] LANE_BASE_4  = 32'h1111_1111;
  localparam logic [31:0] LANE_BASE_2  = 32'h5555_5555;

  // pw is {pw_32, pw_16, pw_8, pw_4, pw_2}. Bit 0 is always a lane base, so
  // an all-zero pw degrades to a single 32-bit lane.
  function automatic logic [31:0] lane_base(input logic [4:0] pw);
    logic [31:0] m;
    m = LANE_BASE_32;
    if (pw[4]) m = m | LANE_BASE_32;
    if (pw[3]) m = m | LANE_BASE_16;
    if (pw[2]) m = m | LANE_BASE_8;
    if (pw[1]) m = m | LANE_BASE_4;
    if (pw[0]) m = m | LANE_BASE_2;
    return m;
  endfunction

endpackage

// File: rtl/xc_malu_padd.sv
// 32-bit packed adder: add, subtract or carryless add on 2/4/8/16/32-bit lanes.
//   lhs_i, rhs_i : operands
//   sub_i        : invert rhs and inject carry 1 at every lane base
//   cin_i        : carry into bit 0 (add only)
//   cen_i        : 0 kills all carries inside a lane (result = lhs ^ rhs)
//   pw_i         : one-hot lane width {32,16,8,4,2}
//   cout_o       : cout_o[i+1] is the raw carry out of bit i; cout_o[0] is bit-0 carry in
//   sum_o        : packed sum
module xc_malu_padd
  import xc_malu_pkg::*;
(
  input  logic [31:0] lhs_i,
  input  logic [31:0] rhs_i,
  input  logic        sub_i,
  input  logic        cin_i,
  input  logic        cen_i,
  input  logic [4:0]  pw_i,
  output logic [32:0] cout_o,
  output logic [31:0] sum_o
);

  logic [31:0] base;
  logic [31:0] rhs_eff;

  assign base    = lane_base(pw_i);
  assign rhs_eff = rhs_i ^ {32{sub_i}};

  // Ripple carry held in a block-local variable so the chain is evaluated in
  // order; lane bases restart the chain instead of taking the previous carry.
  always_comb begin
    logic c;
    logic ci;
    c      = 1'b0;
    ci     = 1'b0;
    sum_o  = '0;
    cout_o = '0;
    cout_o[0] = sub_i | cin_i;
    for (int unsigned i = 0; i < 32; i++) begin
      if (base[i]) ci = sub_i | ((i == 0) & cin_i);
      else         ci = c & cen_i;
      sum_o[i] = lhs_i[i] ^ rhs_eff[i] ^ ci;
      c = (lhs_i[i] & rhs_eff[i]) | (lhs_i[i] & ci) | (rhs_eff[i] & ci);
      cout_o[i+1] = c;
    end
  end

endmodule

// File: rtl/xc_malu_seq.sv
// MALU sequencer: owns the iteration state read by the mul/div/rem/pmul
// datapath, registers the datapath's next-state values while running, and
// hands a registered 64-bit result to execute with a one-cycle ready pulse.
//   clock, resetn          : clock, asynchronous active-low reset
//   valid, flush           : request (operands held until ready), abandon
//   ready, result, busy    : completion pulse, registered result, RUN|DONE
//   count, acc, arg_0/1    : current iteration state, to the datapath
//   n_acc, n_arg_0/1       : next iteration state, from the datapath
//   dp_ready, dp_result    : datapath completion and its result
//   pw_*, padd_*           : shared packed adder, serving the datapath
module xc_malu_seq
  import xc_malu_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             valid,
  input  logic             flush,
  output logic             ready,
  output logic [63:0]      result,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic [63:0]      acc,
  output logic [31:0]      arg_0,
  output logic [31:0]      arg_1,
  input  logic [63:0]      n_acc,
  input  logic [31:0]      n_arg_0,
  input  logic [31:0]      n_arg_1,
  input  logic             dp_ready,
  input  logic [63:0]      dp_result,
  input  logic             pw_32,
  input  logic             pw_16,
  input  logic             pw_8,
  input  logic             pw_4,
  input  logic             pw_2,
  input  logic [31:0]      padd_lhs,
  input  logic [31:0]      padd_rhs,
  input  logic             padd_sub,
  input  logic             padd_cin,
  input  logic             padd_cen,
  output logic [32:0]      padd_cout,
  output logic [31:0]      padd_result
);

  malu_state_e      state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [63:0]      acc_q, acc_d;
  logic [31:0]      arg0_q, arg0_d;
  logic [31:0]      arg1_q, arg1_d;
  logic [63:0]      result_q, result_d;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      arg0_q   <= '0;
      arg1_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      arg0_q   <= arg0_d;
      arg1_q   <= arg1_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    arg0_d   = arg0_q;
    arg1_d   = arg1_q;
    result_d = result_q;
    unique case (state_q)
      ST_IDLE: begin
        count_d = '0;
        acc_d   = '0;
        arg0_d  = '0;
        arg1_d  = '0;
        if (valid) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (dp_ready) begin
          // Iteration state is frozen on the completing cycle.
          result_d = dp_result;
          state_d  = ST_DONE;
        end else begin
          acc_d   = n_acc;
          arg0_d  = n_arg_0;
          arg1_d  = n_arg_1;
          count_d = (count_q == '1) ? count_q : count_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // flush overrides every state; result is deliberately left untouched.
    if (flush) begin
      state_d  = ST_IDLE;
      count_d  = '0;
      acc_d    = '0;
      arg0_d   = '0;
      arg1_d   = '0;
      result_d = result_q;
    end
  end

  assign ready  = (state_q == ST_DONE) && !flush;
  assign busy   = (state_q != ST_IDLE);
  assign result = result_q;
  assign count  = count_q;
  assign acc    = acc_q;
  assign arg_0  = arg0_q;
  assign arg_1  = arg1_q;

  xc_malu_padd u_padd (
    .lhs_i  (padd_lhs),
    .rhs_i  (padd_rhs),
    .sub_i  (padd_sub),
    .cin_i  (padd_cin),
    .cen_i  (padd_cen),
    .pw_i   ({pw_32, pw_16, pw_8, pw_4, pw_2}),
    .cout_o (padd_cout),
    .sum_o  (padd_result)
  );

endmodule

// File: tb/tb_xc_malu_seq.sv
module tb_xc_malu_seq;

  localparam int OP_MUL  = 0;
  localparam int OP_DIV  = 1;
  localparam int OP_PASS = 2;

  logic        clock = 1'b0;
  logic        resetn;
  logic        valid, flush, ready, busy;
  logic [63:0] result, acc, n_acc, dp_result;
  logic [5:0]  count;
  logic [31:0] arg_0, arg_1, n_arg_0, n_arg_1;
  logic        dp_ready;
  logic        pw_32, pw_16, pw_8, pw_4, pw_2;
  logic [31:0] padd_lhs, padd_rhs, padd_result;
  logic        padd_sub, padd_cin, padd_cen;
  logic [32:0] padd_cout;

  // Environment: which operation the datapath stub performs and when it finishes.
  int          op;
  int unsigned lat;
  logic [31:0] rs1, rs2;

  int vectors    = 0;
  int miscompares = 0;

  typedef struct {
    logic [63:0] res;
    logic [5:0]  cnt;
  } exp_t;
  exp_t sb[$];
  exp_t e_mon;
  logic [5:0] cap_count = '0;

  always #5 clock = ~clock;

  xc_malu_seq #(.CNT_W(6)) dut (
    .clock(clock), .resetn(resetn), .valid(valid), .flush(flush),
    .ready(ready), .result(result), .busy(busy), .count(count),
    .acc(acc), .arg_0(arg_0), .arg_1(arg_1),
    .n_acc(n_acc), .n_arg_0(n_arg_0), .n_arg_1(n_arg_1),
    .dp_ready(dp_ready), .dp_result(dp_result),
    .pw_32(pw_32), .pw_16(pw_16), .pw_8(pw_8), .pw_4(pw_4), .pw_2(pw_2),
    .padd_lhs(padd_lhs), .padd_rhs(padd_rhs), .padd_sub(padd_sub),
    .padd_cin(padd_cin), .padd_cen(padd_cen),
    .padd_cout(padd_cout), .padd_result(padd_result)
  );

  // Datapath stub: shift-add multiply, restoring divide, or a pass-through.
  // arg_1 counts RUN cycles; completion when it reaches lat.
  always_comb begin
    logic [32:0] rem;
    int unsigned k;
    k         = 32'(count);
    rem       = '0;
    n_acc     = acc;
    n_arg_0   = arg_0;
    n_arg_1   = arg_1 + 32'd1;
    dp_ready  = (arg_1 == lat);
    dp_result = '0;
    case (op)
      OP_MUL: begin
        if (k < 32 && rs2[k]) n_acc = acc + ({32'b0, rs1} << k);
        dp_result = acc;
      end
      OP_DIV: begin
        if (k < 32) begin
          rem = {acc[31:0], rs1[31-k]};
          if (rem >= {1'b0, rs2}) begin
            n_acc   = {31'b0, rem - {1'b0, rs2}};
            n_arg_0 = {arg_0[30:0], 1'b1};
          end else begin
            n_acc   = {31'b0, rem};
            n_arg_0 = {arg_0[30:0], 1'b0};
          end
        end
        dp_result = {32'b0, arg_0};
      end
      default: dp_result = {rs2, rs1};
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every ready pulse.
  always @(negedge clock) begin
    if (resetn) begin
      if (ready) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_ready: got ready=1 (result %h) expected no pulse", result);
        end else begin
          e_mon = sb.pop_front();
          check("result", result, e_mon.res);
          check("capture_count", 64'(cap_count), 64'(e_mon.cnt));
        end
      end
      if (dp_ready && busy && !ready) cap_count = count;
    end
  end

  task automatic issue(input int o, input logic [31:0] a, input logic [31:0] b,
                       input int unsigned l, input bit hold, input int unsigned extra);
    exp_t e;
    int unsigned n;
    bit got;
    op = o; rs1 = a; rs2 = b; lat = l; valid = 1'b1;
    case (o)
      OP_MUL:  e.res = 64'(a) * 64'(b);
      OP_DIV:  e.res = 64'(a / b);
      default: e.res = {b, a};
    endcase
    e.cnt = (l > 63) ? 6'd63 : 6'(l);
    sb.push_back(e);
    n = 0; got = 0;
    while (n < 200 && !got) begin
      @(negedge clock);
      n++;
      if (ready) got = 1;
    end
    check("latency", 64'(n), 64'(l + 2 + extra));
    if (!hold) valid = 1'b0;
  endtask

  task automatic padd_drive(input int unsigned w, input logic [31:0] l, input logic [31:0] r,
                            input logic s, input logic ci, input logic ce);
    pw_32 = (w == 32); pw_16 = (w == 16); pw_8 = (w == 8); pw_4 = (w == 4); pw_2 = (w == 2);
    padd_lhs = l; padd_rhs = r; padd_sub = s; padd_cin = ci; padd_cen = ce;
    #1;
  endtask

  // Lane-by-lane arithmetic reference for the packed adder.
  task automatic padd_check(input int unsigned w, input logic [31:0] l, input logic [31:0] r,
                            input logic s, input logic ci, input logic ce);
    logic [31:0] er, rr;
    logic [32:0] ec, mask;
    logic [63:0] lv, rv, sum, mw;
    er = '0; ec = '0; mask = '0;
    rr = s ? ~r : r;
    mw = (64'd1 << w) - 64'd1;
    ec[0] = s | ci; mask[0] = 1'b1;
    for (int unsigned k = 0; k < 32 / w; k++) begin
      lv  = (64'(l) >> (k * w)) & mw;
      rv  = (64'(rr) >> (k * w)) & mw;
      sum = ce ? lv + rv + 64'(s || (k == 0 && ci)) : (lv ^ rv);
      er  = er | 32'((sum & mw) << (k * w));
      if (ce) begin
        mask[(k + 1) * w] = 1'b1;
        ec[(k + 1) * w]   = sum[w];
      end
    end
    padd_drive(w, l, r, s, ci, ce);
    check("padd_result", 64'(padd_result), 64'(er));
    check("padd_cout", 64'(padd_cout & mask), 64'(ec));
  endtask

  initial begin
    int unsigned n;
    logic [31:0] a, b;
    int unsigned w;

    resetn = 1'b0; valid = 1'b0; flush = 1'b0;
    op = OP_MUL; lat = 0; rs1 = '0; rs2 = '0;
    padd_drive(32, '0, '0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clock);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_acc", acc, 64'd0);
    check("rst_args", {arg_1, arg_0}, 64'd0);
    resetn = 1'b1;
    @(negedge clock);

    // 7*6, completes at count 32.
    issue(OP_MUL, 32'd7, 32'd6, 32, 1'b0, 0);
    @(negedge clock);

    // Flush in RUN at count 10.
    op = OP_MUL; rs1 = $urandom; rs2 = $urandom; lat = 32; valid = 1'b1;
    n = 0;
    while (n < 100 && count != 6'd10) begin @(negedge clock); n++; end
    check("flush_reach_count10", 64'(count), 64'd10);
    flush = 1'b1; valid = 1'b0;
    @(negedge clock);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_acc", acc, 64'd0);
    check("flush_count", 64'(count), 64'd0);
    check("flush_args", {arg_1, arg_0}, 64'd0);
    check("flush_result_kept", result, 64'd42);
    repeat (3) @(negedge clock);

    // Back-to-back: valid held through DONE, then 100/7.
    issue(OP_MUL, 32'd7, 32'd6, 32, 1'b1, 0);
    issue(OP_DIV, 32'd100, 32'd7, 32, 1'b0, 1);
    @(negedge clock);
    check("b2b_result", result, 64'd14);

    // flush together with valid in IDLE: no start.
    valid = 1'b1; flush = 1'b1;
    @(negedge clock);
    check("flush_idle_busy", 64'(busy), 64'd0);
    valid = 1'b0; flush = 1'b0;
    @(negedge clock);

    // flush during DONE suppresses ready; captured result remains.
    a = $urandom; b = $urandom;
    op = OP_PASS; rs1 = a; rs2 = b; lat = 3; valid = 1'b1;
    n = 0;
    while (n < 20 && !(busy && dp_ready && !ready)) begin @(negedge clock); n++; end
    check("flushdone_reach", 64'(busy && dp_ready), 64'd1);
    valid = 1'b0;
    @(posedge clock); #1;
    flush = 1'b1;
    #1;
    check("flushdone_busy", 64'(busy), 64'd1);
    check("flushdone_ready", 64'(ready), 64'd0);
    @(posedge clock); #1;
    flush = 1'b0;
    @(negedge clock);
    check("flushdone_idle", 64'(busy), 64'd0);
    check("flushdone_result", result, {b, a});
    @(negedge clock);

    // Count saturation: 70 RUN cycles before completion.
    issue(OP_MUL, $urandom, $urandom, 70, 1'b0, 0);
    @(negedge clock);

    // Random operations, including minimum-latency pass-through.
    for (int i = 0; i < 24; i++) begin
      int o;
      o = int'($urandom_range(0, 2));
      a = $urandom;
      b = $urandom;
      if (o == OP_DIV && b == 0) b = 32'd1;
      if (o == OP_DIV && (i % 3) == 0) b = b >> $urandom_range(16, 31);
      if (b == 0) b = 32'd3;
      if (o == OP_PASS) issue(o, a, b, $urandom_range(0, 6), 1'b0, 0);
      else              issue(o, a, b, $urandom_range(32, 40), 1'b0, 0);
      repeat ($urandom_range(1, 2)) @(negedge clock);
    end

    // Asynchronous reset mid-RUN.
    op = OP_MUL; rs1 = 32'hFFFF_FFFF; rs2 = 32'hFFFF_FFFF; lat = 32; valid = 1'b1;
    repeat (6) @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_ready", 64'(ready), 64'd0);
    check("arst_count", 64'(count), 64'd0);
    check("arst_acc", acc, 64'd0);
    check("arst_args", {arg_1, arg_0}, 64'd0);
    check("arst_result", result, 64'd0);
    valid = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);

    // Packed adder directed cases.
    padd_drive(8, 32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 1'b1);
    check("padd_b8_sum", 64'(padd_result), 64'h0);
    check("padd_b8_c8", 64'(padd_cout[8]), 64'd1);
    check("padd_b8_c24", 64'(padd_cout[24]), 64'd1);
    padd_drive(16, 32'h0005_0003, 32'h0001_0004, 1'b1, 1'b0, 1'b1);
    check("padd_sub16", 64'(padd_result), 64'h0004_FFFF);
    padd_drive(32, 32'h0F0F_0F0F, 32'hFF00_FF00, 1'b0, 1'b0, 1'b0);
    check("padd_carryless", 64'(padd_result), 64'hF00F_F00F);
    padd_check(8, 32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 1'b1);
    padd_check(16, 32'h0005_0003, 32'h0001_0004, 1'b1, 1'b0, 1'b1);
    padd_check(4, 32'h0F0F_0F0F, 32'hFF00_FF00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      w = 32'd2 << $urandom_range(0, 4);
      padd_check(w, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'b1);
    end

    repeat (3) @(negedge clock);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
